// File: rtl/vlsu_ctrl.sv
// vlsu_ctrl: vector load/store sequencer between the vector decoder and the
// single-outstanding word-wide data-memory port. Packs/unpacks 8/16/32-bit
// elements and pulses vlsu_ready_o once per completed vector-register word.
// Optional feature macro: VLSU_STRIDED_EN (strided per-element sequencing,
// element counter and load pack buffer). Undefined builds are unit-stride only.
module vlsu_ctrl (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        vlsu_en_i,
   input  logic        vlsu_load_i,
   input  logic        vlsu_store_i,
   input  logic        vlsu_strided_i,
   input  logic [31:0] base_addr_i,
   input  logic [31:0] stride_i,
   input  logic [4:0]  vl_i,
   input  logic [1:0]  vsew_i,
   input  logic [31:0] vs3_data_i,
   output logic        vlsu_ready_o,
   output logic [1:0]  word_idx_o,
   output logic        vr_we_o,
   output logic [3:0]  vr_be_o,
   output logic [31:0] vr_wdata_o,
   output logic        data_req_o,
   input  logic        data_gnt_i,
   output logic [31:0] data_addr_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_RESP,
      S_FIN
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   // latched operation
   logic        r_load;
   logic [29:0] r_base_w;
   logic [4:0]  r_vl;
   logic [1:0]  r_vsew;
   logic [4:0]  r_wlast;
   logic [4:0]  r_word;
   logic        r_zero_pulse;
   logic        r_req_first;
   logic [31:0] r_vs3;

   logic        w_start;
   logic [1:0]  w_vsew_in;
   logic [31:0] w_vs3;

   // unit-stride path
   logic [31:0] w_uaddr;
   logic [4:0]  w_rem;
   logic [6:0]  w_nb;
   logic [3:0]  w_ube_last;
   logic [3:0]  w_ube;
   logic        w_ulast;

   // selected transaction view
   logic [31:0] w_addr;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic        w_word_done;
   logic        w_last_txn;
   logic [31:0] w_vr_data;
   logic [3:0]  w_vr_be;

   assign w_start   = (r_state == S_IDLE) && vlsu_en_i && (vlsu_load_i || vlsu_store_i);
   assign w_vsew_in = (vsew_i == 2'd3) ? 2'd2 : vsew_i;

   // Store data is taken live in the first REQ cycle of a word (the decoder
   // has just advanced to the new word index) and held afterwards.
   assign w_vs3 = r_req_first ? vs3_data_i : r_vs3;

   assign w_uaddr = {r_base_w + {25'd0, r_word}, 2'b00};
   assign w_ulast = (r_word == r_wlast);
   assign w_rem   = r_vl - (r_word << (2'd2 - r_vsew));
   assign w_nb    = {2'b00, w_rem} << r_vsew;

   // byte mask for the remaining bytes of the final unit-stride word
   always_comb begin
      w_ube_last = 4'b1111;
      case (w_nb)
         7'd1:    w_ube_last = 4'b0001;
         7'd2:    w_ube_last = 4'b0011;
         7'd3:    w_ube_last = 4'b0111;
         default: w_ube_last = 4'b1111;
      endcase
   end

   assign w_ube = w_ulast ? w_ube_last : 4'b1111;

`ifdef VLSU_STRIDED_EN
   logic        r_strided;
   logic [31:0] r_stride;
   logic [31:0] r_eaddr;
   logic [31:0] r_pack;
   logic [4:0]  r_elem;

   logic [31:0] w_ealign;
   logic [3:0]  w_emask;
   logic [31:0] w_ebits;
   logic [1:0]  w_lane;
   logic [1:0]  w_laneoff;
   logic        w_lane_full;
   logic        w_elast;
   logic [31:0] w_sdata;
   logic [31:0] w_lplaced;
   logic [31:0] w_merged;
   logic [2:0]  w_snb;
   logic [3:0]  w_sbe_vr;

   // per-element alignment, lane position and element masks
   always_comb begin
      w_ealign    = r_eaddr;
      w_emask     = 4'b1111;
      w_ebits     = '1;
      w_lane      = 2'd0;
      w_laneoff   = 2'd0;
      w_lane_full = 1'b1;
      case (r_vsew)
         2'd0: begin
            w_ealign    = r_eaddr;
            w_emask     = 4'b0001;
            w_ebits     = 32'h0000_00FF;
            w_lane      = r_elem[1:0];
            w_laneoff   = r_elem[1:0];
            w_lane_full = (r_elem[1:0] == 2'd3);
         end
         2'd1: begin
            w_ealign    = {r_eaddr[31:1], 1'b0};
            w_emask     = 4'b0011;
            w_ebits     = 32'h0000_FFFF;
            w_lane      = {1'b0, r_elem[0]};
            w_laneoff   = {r_elem[0], 1'b0};
            w_lane_full = r_elem[0];
         end
         default: begin
            w_ealign    = {r_eaddr[31:2], 2'b00};
            w_emask     = 4'b1111;
            w_ebits     = '1;
            w_lane      = 2'd0;
            w_laneoff   = 2'd0;
            w_lane_full = 1'b1;
         end
      endcase
   end

   assign w_elast   = (r_elem == (r_vl - 5'd1));
   assign w_sdata   = ((w_vs3 >> {w_laneoff, 3'b000}) & w_ebits) << {w_ealign[1:0], 3'b000};
   assign w_lplaced = ((data_rdata_i >> {w_ealign[1:0], 3'b000}) & w_ebits) << {w_laneoff, 3'b000};
   assign w_merged  = r_pack | w_lplaced;
   assign w_snb     = {1'b0, w_laneoff} + (3'd1 << r_vsew);
   assign w_sbe_vr  = (w_snb == 3'd1) ? 4'b0001 :
                      (w_snb == 3'd2) ? 4'b0011 :
                      (w_snb == 3'd3) ? 4'b0111 : 4'b1111;

   // choose strided or unit-stride view of the current transaction
   always_comb begin
      w_addr      = w_uaddr;
      w_be        = w_ube;
      w_wdata     = w_vs3;
      w_word_done = 1'b1;
      w_last_txn  = w_ulast;
      w_vr_data   = data_rdata_i;
      w_vr_be     = w_ube;
      if (r_strided) begin
         w_addr      = {w_ealign[31:2], 2'b00};
         w_be        = w_emask << w_ealign[1:0];
         w_wdata     = w_sdata;
         w_word_done = w_lane_full || w_elast;
         w_last_txn  = w_elast;
         w_vr_data   = w_merged;
         w_vr_be     = w_sbe_vr;
      end
   end

   // strided element sequencing and load pack buffer
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_strided <= 1'b0;
         r_stride  <= '0;
         r_eaddr   <= '0;
         r_pack    <= '0;
         r_elem    <= '0;
      end else if (w_start) begin
         r_strided <= vlsu_strided_i;
         r_stride  <= stride_i;
         r_eaddr   <= base_addr_i;
         r_pack    <= '0;
         r_elem    <= '0;
      end else if ((r_state == S_RESP) && data_rvalid_i) begin
         r_elem  <= r_elem + 5'd1;
         r_eaddr <= r_eaddr + r_stride;
         r_pack  <= w_word_done ? '0 : w_merged;
      end
   end
`else
   logic w_unused;
   assign w_unused = ^{stride_i, vlsu_strided_i, base_addr_i[1:0]};

   assign w_addr      = w_uaddr;
   assign w_be        = w_ube;
   assign w_wdata     = w_vs3;
   assign w_word_done = 1'b1;
   assign w_last_txn  = w_ulast;
   assign w_vr_data   = data_rdata_i;
   assign w_vr_be     = w_ube;
`endif

   assign word_idx_o = r_word[1:0];

   // state register
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // operation latch, word counter and store-data hold
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_load       <= 1'b0;
         r_base_w     <= '0;
         r_vl         <= '0;
         r_vsew       <= '0;
         r_wlast      <= '0;
         r_word       <= '0;
         r_zero_pulse <= 1'b0;
         r_req_first  <= 1'b0;
         r_vs3        <= '0;
      end else begin
         r_zero_pulse <= 1'b0;
         if (w_start) begin
            r_load       <= vlsu_load_i;
            r_base_w     <= base_addr_i[31:2];
            r_vl         <= vl_i;
            r_vsew       <= w_vsew_in;
            r_wlast      <= (vl_i - 5'd1) >> (2'd2 - w_vsew_in);
            r_word       <= '0;
            r_zero_pulse <= (vl_i == 5'd0);
            r_req_first  <= 1'b1;
         end
         if (r_state == S_REQ) begin
            r_req_first <= 1'b0;
            if (r_req_first) begin
               r_vs3 <= vs3_data_i;
            end
         end
         if ((r_state == S_RESP) && data_rvalid_i) begin
            r_req_first <= w_word_done;
            if (w_word_done) begin
               r_word <= r_word + 5'd1;
            end
         end
      end
   end

   // next state and port outputs
   always_comb begin
      w_state_nxt  = r_state;
      vlsu_ready_o = 1'b0;
      vr_we_o      = 1'b0;
      vr_be_o      = 4'b0000;
      vr_wdata_o   = '0;
      data_req_o   = 1'b0;
      data_addr_o  = '0;
      data_we_o    = 1'b0;
      data_be_o    = 4'b0000;
      data_wdata_o = '0;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_state_nxt = (vl_i == 5'd0) ? S_FIN : S_REQ;
            end
         end
         S_REQ: begin
            data_req_o   = 1'b1;
            data_addr_o  = w_addr;
            data_be_o    = w_be;
            data_we_o    = !r_load;
            data_wdata_o = r_load ? '0 : w_wdata;
            if (data_gnt_i) begin
               w_state_nxt = S_RESP;
            end
         end
         S_RESP: begin
            if (data_rvalid_i) begin
               if (w_word_done) begin
                  vlsu_ready_o = 1'b1;
                  if (r_load) begin
                     vr_we_o    = 1'b1;
                     vr_be_o    = w_vr_be;
                     vr_wdata_o = w_vr_data;
                  end
               end
               w_state_nxt = w_last_txn ? S_FIN : S_REQ;
            end
         end
         S_FIN: begin
            vlsu_ready_o = r_zero_pulse;
            if (!vlsu_en_i) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule
